pcpi_approx_issuer: RTL and testbench

Initiator side of the PCPI custom-instruction interface: accepts approximate-multiply commands (funct3 plus two 32-bit operands) on a valid/ready command port and drives `pcpi_valid`/`pcpi_insn`/`pcpi_rs1`/`pcpi_rs2` toward a PCPI responder. It then collects `pcpi_rd` and returns it on a valid/ready response port. It sits between a bus-mapped accelerator front-end (or a test sequencer) and the approximate-multiply coprocessor, so the coprocessor can be exercised without the CPU. It enforces the PCPI timeout rule and keeps saturating completion and timeout counters.

---
 rtl/pcpi_approx_issuer.sv | 149 ++++++++++++++
 tb/tb_pcpi_approx_issuer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_approx_issuer.sv
// pcpi_approx_issuer: drives one PCPI approximate-multiply transaction per
// accepted command and returns the responder's result on a response port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready is high only in IDLE. rsp_valid is high only in RESP
// and holds rsp_data/rsp_wr/rsp_err stable until rsp_ready is seen.
module pcpi_approx_issuer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_funct3,
    input  logic [31:0] cmd_rs1,
    input  logic [31:0] cmd_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_wr,
    output logic        rsp_err,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic [15:0] stat_done,
    output logic [15:0] stat_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Timer value on which a silent responder is abandoned.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] timer;
    logic       accept;
    logic       done_hit;
    logic       timeout_hit;

    // Command is refused while reset is held, even if the state is IDLE.
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = (state_q == RESP);
    assign state     = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle transaction events.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ, WAIT: begin
                // A ready in the last timer cycle wins over the timeout.
                if (pcpi_ready) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (!pcpi_wait && timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request/response registers, timeout timer and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcpi_valid   <= 1'b0;
            pcpi_insn    <= 32'd0;
            pcpi_rs1     <= 32'd0;
            pcpi_rs2     <= 32'd0;
            rsp_data     <= 32'd0;
            rsp_wr       <= 1'b0;
            rsp_err      <= 1'b0;
            stat_done    <= 16'd0;
            stat_timeout <= 16'd0;
            timer        <= 8'd0;
        end else begin
            if (accept) begin
                pcpi_valid <= 1'b1;
                pcpi_insn  <= {7'b0000001, 5'd0, 5'd0, cmd_funct3, 5'd0, 7'b0001011};
                pcpi_rs1   <= cmd_rs1;
                pcpi_rs2   <= cmd_rs2;
                timer      <= 8'd0;
            end
            if (state_q == REQ || state_q == WAIT) begin
                if (pcpi_wait) begin
                    timer <= 8'd0;
                end else if (!pcpi_ready) begin
                    timer <= timer + 8'd1;
                end
            end
            if (done_hit) begin
                pcpi_valid <= 1'b0;
                rsp_data   <= pcpi_wr ? pcpi_rd : 32'd0;
                rsp_wr     <= pcpi_wr;
                rsp_err    <= 1'b0;
                if (stat_done != 16'hFFFF) begin
                    stat_done <= stat_done + 16'd1;
                end
            end
            if (timeout_hit) begin
                pcpi_valid <= 1'b0;
                rsp_data   <= 32'd0;
                rsp_wr     <= 1'b0;
                rsp_err    <= 1'b1;
                if (stat_timeout != 16'hFFFF) begin
                    stat_timeout <= stat_timeout + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcpi_approx_issuer.sv
// Directed testbench for pcpi_approx_issuer. The bench plays the PCPI
// responder; inputs are driven and outputs sampled on the falling edge, so a
// value driven at the falling edge of cycle k is what the DUT samples at the
// end of cycle k.
module tb_pcpi_approx_issuer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_funct3;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_err;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic [15:0] stat_done;
    logic [15:0] stat_timeout;
    logic [1:0]  state;

    int n_cmp  = 0;
    int n_fail = 0;

    pcpi_approx_issuer #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct3(cmd_funct3),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_wr(rsp_wr), .rsp_err(rsp_err),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
        .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .stat_done(stat_done), .stat_timeout(stat_timeout), .state(state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Drive one command while the DUT sits in IDLE; returns at the falling
    // edge of cycle E+1 (the REQ cycle).
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        cmd_valid  = 1'b1;
        cmd_funct3 = f3;
        cmd_rs1    = a;
        cmd_rs2    = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready_during: got %b want 0", cmd_ready); end
        n_cmp++; if (pcpi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pcpi_valid: got %b want 0", pcpi_valid); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready); end
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++;
        if ({pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_data} !== 128'd0) begin
            n_fail++; $display("FAIL reset_regs: got insn=%h rs1=%h rs2=%h data=%h want all 0", pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_data);
        end
        n_cmp++;
        if ({rsp_valid, rsp_wr, rsp_err, stat_done, stat_timeout} !== 35'd0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b wr=%b err=%b done=%0d tmo=%0d want all 0", rsp_valid, rsp_wr, rsp_err, stat_done, stat_timeout);
        end
    endtask

    // Registered responder: ready one cycle after pcpi_valid first seen.
    task automatic test_registered();
        int hi_cnt;
        rsp_ready = 1'b0;
        issue(3'b000, 32'h0003_0002, 32'h0005_0007);
        hi_cnt = pcpi_valid ? 1 : 0;
        n_cmp++; if (pcpi_insn !== 32'h0200_000B) begin n_fail++; $display("FAIL reg_insn: got %h want 0200000b", pcpi_insn); end
        n_cmp++; if (pcpi_rs1 !== 32'h0003_0002 || pcpi_rs2 !== 32'h0005_0007) begin n_fail++; $display("FAIL reg_operands: got %h %h want 00030002 00050007", pcpi_rs1, pcpi_rs2); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reg_cmd_ready_busy: got %b want 0", cmd_ready); end
        @(negedge clk);
        if (pcpi_valid) hi_cnt++;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reg_rsp_early: got %b want 0 at E+2", rsp_valid); end
        // Responder result {3*5, 2*7}.
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h000F_000E;
        @(negedge clk);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        if (pcpi_valid) hi_cnt++;
        n_cmp++; if (hi_cnt !== 2) begin n_fail++; $display("FAIL reg_valid_cycles: got %0d want 2", hi_cnt); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL reg_rsp_latency: got %b want 1 at E+3", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h000F_000E) begin n_fail++; $display("FAIL reg_rsp_data: got %h want 000f000e", rsp_data); end
        n_cmp++; if (rsp_wr !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reg_rsp_flags: got wr=%b err=%b want 1 0", rsp_wr, rsp_err); end
        n_cmp++; if (stat_done !== 16'd1) begin n_fail++; $display("FAIL reg_stat_done: got %0d want 1", stat_done); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reg_consume: got rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready); end
    endtask

    // Combinational responder with pcpi_wr=0: result forced to zero.
    task automatic test_comb_nowr();
        issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        n_cmp++; if (pcpi_insn !== 32'h0200_100B) begin n_fail++; $display("FAIL comb_insn: got %h want 0200100b", pcpi_insn); end
        pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'h0000_1234;
        @(negedge clk);
        pcpi_ready = 1'b0; pcpi_rd = 32'd0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL comb_latency: got %b want 1 at E+2", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'd0 || rsp_wr !== 1'b0) begin n_fail++; $display("FAIL comb_nowr: got data=%h wr=%b want 0 0", rsp_data, rsp_wr); end
        n_cmp++; if (stat_done !== 16'd2) begin n_fail++; $display("FAIL comb_stat_done: got %0d want 2", stat_done); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Three commands back to back against a responder whose ready lags
    // pcpi_valid by one cycle, so it also asserts a stale ready in RESP.
    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        logic        prev_valid = 1'b0;
        logic        acc_now;
        int accepted = 0, responses = 0, pulses = 0, run = 0, max_run = 0;
        int first_acc = -1, third_acc = -1, bad_insn = 0, bad_data = 0;
        rsp_ready  = 1'b1;
        cmd_funct3 = 3'b010;
        cmd_rs1    = 32'h1111_0000;
        cmd_rs2    = 32'h0000_2222;
        cmd_valid  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            pcpi_ready = prev_valid;
            pcpi_wr    = prev_valid;
            pcpi_rd    = prev_valid ? (pcpi_rs1 ^ pcpi_rs2) : 32'd0;
            if (pcpi_valid && !prev_valid) begin
                pulses++;
                if (pcpi_insn !== 32'h0200_200B) bad_insn++;
            end
            run = pcpi_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (rsp_valid && rsp_ready) begin
                responses++;
                if (exp_q.size() == 0) begin
                    bad_data++;
                end else begin
                    exp = exp_q.pop_front();
                    if (rsp_data !== exp) bad_data++;
                end
            end
            acc_now = cmd_valid && cmd_ready;
            if (acc_now) begin
                exp_q.push_back(cmd_rs1 ^ cmd_rs2);
                accepted++;
                if (accepted == 1) first_acc = cyc;
                if (accepted == 3) third_acc = cyc;
            end
            prev_valid = pcpi_valid;
            @(negedge clk);
            if (acc_now) begin
                if (accepted == 3) begin
                    cmd_valid = 1'b0;
                end else begin
                    cmd_rs1 = cmd_rs1 + 32'h0101_0101;
                    cmd_rs2 = {cmd_rs2[15:0], cmd_rs2[31:16]};
                end
            end
        end
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        rsp_ready  = 1'b0;
        n_cmp++; if (accepted !== 3 || responses !== 3) begin n_fail++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 3 3", accepted, responses); end
        n_cmp++; if (pulses !== 3 || max_run !== 2) begin n_fail++; $display("FAIL b2b_pulses: got pulses=%0d max_run=%0d want 3 2", pulses, max_run); end
        n_cmp++; if (third_acc - first_acc !== 8) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles for 2 intervals want 8", third_acc - first_acc); end
        n_cmp++; if (bad_data !== 0 || bad_insn !== 0) begin n_fail++; $display("FAIL b2b_data: got bad_data=%0d bad_insn=%0d want 0 0", bad_data, bad_insn); end
        n_cmp++; if (stat_done !== 16'd5) begin n_fail++; $display("FAIL b2b_stat_done: got %0d want 5", stat_done); end
    endtask

    // Silent responder: abort after TIMEOUT cycles.
    task automatic test_timeout();
        int k;
        pcpi_ready = 1'b0; pcpi_wait = 1'b0;
        issue(3'b000, 32'hCAFE_0001, 32'hCAFE_0002);
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k !== 17) begin n_fail++; $display("FAIL tmo_latency: got rsp_valid at E+%0d want E+17", k); end
        n_cmp++; if (rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_wr !== 1'b0) begin n_fail++; $display("FAIL tmo_rsp: got err=%b data=%h wr=%b want 1 0 0", rsp_err, rsp_data, rsp_wr); end
        n_cmp++; if (stat_timeout !== 16'd1 || stat_done !== 16'd5) begin n_fail++; $display("FAIL tmo_stats: got tmo=%0d done=%0d want 1 5", stat_timeout, stat_done); end
        n_cmp++; if (pcpi_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_valid_drop: got %b want 0", pcpi_valid); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Long pcpi_wait holds off the timeout.
    task automatic test_wait();
        int early = 0;
        pcpi_wait = 1'b1;
        issue(3'b000, 32'h0000_0010, 32'h0000_0020);
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid !== 1'b0 || pcpi_valid !== 1'b1) early++;
            @(negedge clk);
        end
        n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL wait_hold: got %0d bad cycles want 0", early); end
        pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL wait_rsp: got valid=%b err=%b want 1 0", rsp_valid, rsp_err); end
        n_cmp++; if (rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wait_data: got %h want deadbeef", rsp_data); end
        n_cmp++; if (stat_timeout !== 16'd1 || stat_done !== 16'd6) begin n_fail++; $display("FAIL wait_stats: got tmo=%0d done=%0d want 1 6", stat_timeout, stat_done); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Stalled consumer: response held, no new command accepted.
    task automatic test_backpressure();
        int unstable = 0;
        rsp_ready = 1'b0;
        issue(3'b000, 32'hAAAA_0001, 32'h5555_0002);
        cmd_valid = 1'b1; cmd_funct3 = 3'b001; cmd_rs1 = 32'h7777_0003; cmd_rs2 = 32'h8888_0004;
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hA5A5_0001;
        @(negedge clk);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== 32'hA5A5_0001 || pcpi_valid !== 1'b0) unstable++;
            @(negedge clk);
        end
        n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d bad cycles want 0", unstable); end
        rsp_ready = 1'b1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept_in_resp: got cmd_ready=%b want 0", cmd_ready); end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++; if (pcpi_valid !== 1'b1 || pcpi_rs1 !== 32'h7777_0003 || pcpi_insn !== 32'h0200_100B) begin
            n_fail++; $display("FAIL bp_next_cmd: got valid=%b rs1=%h insn=%h want 1 77770003 0200100b", pcpi_valid, pcpi_rs1, pcpi_insn);
        end
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0000_0042;
        @(negedge clk);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        n_cmp++; if (rsp_data !== 32'h0000_0042 || stat_done !== 16'd8) begin n_fail++; $display("FAIL bp_second_rsp: got data=%h done=%0d want 00000042 8", rsp_data, stat_done); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Reset while the responder is stalling, then a clean transaction.
    task automatic test_reset_mid();
        pcpi_wait = 1'b1;
        issue(3'b010, 32'h0BAD_0BAD, 32'h0F0F_0F0F);
        repeat (2) @(negedge clk);
        n_cmp++; if (pcpi_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got pcpi_valid=%b want 1", pcpi_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (pcpi_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got valid=%b rsp_valid=%b cmd_ready=%b want 0 0 0", pcpi_valid, rsp_valid, cmd_ready); end
        n_cmp++; if (pcpi_insn !== 32'd0 || stat_done !== 16'd0 || stat_timeout !== 16'd0) begin n_fail++; $display("FAIL rmid_regs: got insn=%h done=%0d tmo=%0d want 0 0 0", pcpi_insn, stat_done, stat_timeout); end
        reset = 1'b0; pcpi_wait = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1 || state !== 2'd0) begin n_fail++; $display("FAIL rmid_idle: got cmd_ready=%b state=%0d want 1 0", cmd_ready, state); end
        issue(3'b000, 32'h0002_0004, 32'h0003_0005);
        @(negedge clk);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0006_0014;
        @(negedge clk);
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0006_0014 || stat_done !== 16'd1) begin
            n_fail++; $display("FAIL rmid_after: got valid=%b data=%h done=%0d want 1 00060014 1", rsp_valid, rsp_data, stat_done);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Test sequence and final report.
    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_funct3 = 3'b000; cmd_rs1 = 32'd0; cmd_rs2 = 32'd0;
        rsp_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_registered();
        test_comb_nowr();
        test_back_to_back();
        test_timeout();
        test_wait();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
